// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin write arbiter for a small register file, with a
// scrub sequence that zeroes every implemented entry on request.
module rf_write_arbiter #(
   parameter int NREG = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [3:0]  addr_a,
   input  logic [3:0]  addr_b,
   input  logic [31:0] data_a,
   input  logic [31:0] data_b,
   input  logic        init,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        err_a,
   output logic        err_b,
   output logic        busy,
   output logic        done,
   output logic        we,
   output logic [3:0]  wAddr,
   output logic [31:0] wData
);

   typedef enum logic {RUN, SCRUB} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NREG - 1);

   state_t      state, state_nxt;
   logic [3:0]  scrub_cnt, scrub_cnt_nxt;
   logic        prio_a, prio_a_nxt;
   logic        gnt_a_nxt, gnt_b_nxt, err_a_nxt, err_b_nxt;
   logic        busy_nxt, done_nxt, we_nxt;
   logic [3:0]  waddr_nxt;
   logic [31:0] wdata_nxt;

   logic elig_a, elig_b, win_a, win_b, bad_a, bad_b;

   // A requester that is being granted this cycle sits out the next arbitration.
   assign elig_a = req_a & ~gnt_a;
   assign elig_b = req_b & ~gnt_b;
   assign win_a  = elig_a & (~elig_b | prio_a);
   assign win_b  = elig_b & (~elig_a | ~prio_a);
   assign bad_a  = ({1'b0, addr_a} >= 5'(NREG));
   assign bad_b  = ({1'b0, addr_b} >= 5'(NREG));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         scrub_cnt <= '0;
         prio_a    <= 1'b1;
         gnt_a     <= 1'b0;
         gnt_b     <= 1'b0;
         err_a     <= 1'b0;
         err_b     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         we        <= 1'b0;
         wAddr     <= '0;
         wData     <= '0;
      end else begin
         // NOTE: non-blocking here so every register samples pre-edge values.
         state     <= state_nxt;
         scrub_cnt <= scrub_cnt_nxt;
         prio_a    <= prio_a_nxt;
         gnt_a     <= gnt_a_nxt;
         gnt_b     <= gnt_b_nxt;
         err_a     <= err_a_nxt;
         err_b     <= err_b_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         we        <= we_nxt;
         wAddr     <= waddr_nxt;
         wData     <= wdata_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (init) state_nxt = SCRUB;
         SCRUB:   if (scrub_cnt == LAST_IDX) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Computes the next value of every registered output, so no input reaches
   // an output port without passing through a flop.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      gnt_a_nxt     = 1'b0;
      gnt_b_nxt     = 1'b0;
      err_a_nxt     = 1'b0;
      err_b_nxt     = 1'b0;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      we_nxt        = 1'b0;
      waddr_nxt     = wAddr;
      wdata_nxt     = wData;
      scrub_cnt_nxt = scrub_cnt;
      prio_a_nxt    = prio_a;
      case (state)
         RUN: begin
            if (init) begin
               busy_nxt      = 1'b1;
               we_nxt        = 1'b1;
               waddr_nxt     = '0;
               wdata_nxt     = '0;
               scrub_cnt_nxt = '0;
            end else if (win_a) begin
               gnt_a_nxt  = 1'b1;
               err_a_nxt  = bad_a;
               we_nxt     = ~bad_a;
               waddr_nxt  = addr_a;
               wdata_nxt  = data_a;
               prio_a_nxt = 1'b0;
            end else if (win_b) begin
               gnt_b_nxt  = 1'b1;
               err_b_nxt  = bad_b;
               we_nxt     = ~bad_b;
               waddr_nxt  = addr_b;
               wdata_nxt  = data_b;
               prio_a_nxt = 1'b1;
            end
         end
         SCRUB: begin
            // scrub_cnt names the entry currently on the write port.
            if (scrub_cnt == LAST_IDX) begin
               done_nxt = 1'b1;
            end else begin
               busy_nxt      = 1'b1;
               we_nxt        = 1'b1;
               scrub_cnt_nxt = scrub_cnt + 4'd1;
               waddr_nxt     = scrub_cnt + 4'd1;
               wdata_nxt     = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected outputs are queued as stimulus
// is applied and compared one cycle later when the DUT registers its result.
module tb_rf_write_arbiter;
   localparam int NREG = 8;

   logic        clk;
   logic        reset_n;
   logic        req_a, req_b, init;
   logic [3:0]  addr_a, addr_b;
   logic [31:0] data_a, data_b;
   logic        gnt_a, gnt_b, err_a, err_b, busy, done, we;
   logic [3:0]  wAddr;
   logic [31:0] wData;

   rf_write_arbiter #(.NREG(NREG)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_a(req_a), .req_b(req_b),
      .addr_a(addr_a), .addr_b(addr_b),
      .data_a(data_a), .data_b(data_b),
      .init(init),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .err_a(err_a), .err_b(err_b),
      .busy(busy), .done(done),
      .we(we), .wAddr(wAddr), .wData(wData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic gnt_a, gnt_b, err_a, err_b, we, busy, done;
   } ctl_t;

   typedef struct {
      ctl_t        ctl;
      logic        chk_w;
      logic [3:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   string       tag = "none";
   logic        m_known;
   logic [3:0]  m_waddr;
   logic [31:0] m_wdata;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s/%s: observed %h expected %h", tag, name, got, expv);
      end
   endtask

   function automatic ctl_t mk(input logic ga, gb, ea, eb, w, b, d);
      ctl_t r;
      r = {ga, gb, ea, eb, w, b, d};
      return r;
   endfunction

   function automatic ctl_t ctl_now();
      ctl_t r;
      r = {gnt_a, gnt_b, err_a, err_b, we, busy, done};
      return r;
   endfunction

   task automatic push(input ctl_t ctl);
      exp_t e;
      e.ctl   = ctl;
      e.chk_w = m_known;
      e.waddr = m_waddr;
      e.wdata = m_wdata;
      sb.push_back(e);
   endtask

   task automatic exp_idle();
      push(mk(0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic exp_gnt_a(input logic [3:0] a, input logic [31:0] d);
      m_known = 1'b1; m_waddr = a; m_wdata = d;
      push(mk(1, 0, 0, 0, 1, 0, 0));
   endtask

   task automatic exp_gnt_b(input logic [3:0] a, input logic [31:0] d);
      m_known = 1'b1; m_waddr = a; m_wdata = d;
      push(mk(0, 1, 0, 0, 1, 0, 0));
   endtask

   task automatic exp_err_b();
      m_known = 1'b0;
      push(mk(0, 1, 0, 1, 0, 0, 0));
   endtask

   task automatic exp_scrub(input logic [3:0] a);
      m_known = 1'b1; m_waddr = a; m_wdata = '0;
      push(mk(0, 0, 0, 0, 1, 1, 0));
   endtask

   task automatic exp_done();
      push(mk(0, 0, 0, 0, 0, 0, 1));
   endtask

   // Advance one edge, then compare the oldest queued expectation.
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("ctl", 32'(ctl_now()), 32'(e.ctl));
      if (e.chk_w) begin
         check("wAddr", 32'(wAddr), 32'(e.waddr));
         check("wData", wData, e.wdata);
      end
   endtask

   task automatic check_quiet();
      check("ctl", 32'(ctl_now()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
      check("wAddr", 32'(wAddr), 32'd0);
      check("wData", wData, 32'd0);
      m_known = 1'b1; m_waddr = '0; m_wdata = '0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      check_quiet();
      @(posedge clk);
      #1;
   endtask

   task automatic run_scrub();
      for (int i = 0; i < NREG; i++) begin
         exp_scrub(4'(i));
         cycle();
         if (i == 1) init = 1'b0;
      end
      exp_done();
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b1;
      req_a = 0; req_b = 0; init = 0;
      addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
      m_known = 1'b1; m_waddr = '0; m_wdata = '0;
      #1;
      tag = "reset";
      apply_reset();
      @(posedge clk);
      #1;

      // Lone requester: granted on the first edge after release, then every other cycle.
      tag = "single_a";
      reset_n = 1'b1;
      req_a = 1; addr_a = 4'd3; data_a = 32'hDEADBEEF;
      exp_gnt_a(4'd3, 32'hDEADBEEF); cycle();
      exp_idle();                    cycle();
      exp_gnt_a(4'd3, 32'hDEADBEEF); cycle();
      req_a = 0;
      exp_idle();                    cycle();

      // Both requesting continuously after reset: A, B, A, B.
      tag = "tie_rr";
      apply_reset();
      reset_n = 1'b1;
      req_a = 1; addr_a = 4'd1; data_a = 32'hA1A1_0001;
      req_b = 1; addr_b = 4'd2; data_b = 32'hB2B2_0002;
      for (int i = 0; i < 2; i++) begin
         exp_gnt_a(4'd1, 32'hA1A1_0001); cycle();
         exp_gnt_b(4'd2, 32'hB2B2_0002); cycle();
      end
      req_a = 0; req_b = 0;
      exp_idle(); cycle();

      // Out-of-range write from B still moves the pointer, so the next tie goes to A.
      tag = "err_b";
      req_a = 1; addr_a = 4'd5; data_a = 32'h5555_0005;
      exp_gnt_a(4'd5, 32'h5555_0005); cycle();
      req_a = 0;
      req_b = 1; addr_b = 4'd9; data_b = 32'h9999_0009;
      exp_err_b(); cycle();
      req_b = 0;
      exp_idle(); cycle();
      req_a = 1; addr_a = 4'd6; data_a = 32'h6666_0006;
      req_b = 1; addr_b = 4'd4; data_b = 32'h4444_0004;
      exp_gnt_a(4'd6, 32'h6666_0006); cycle();
      req_a = 0; req_b = 0;
      exp_idle(); cycle();

      // Scrub with A pending; init held across the first scrub edge is ignored.
      tag = "scrub_req_a";
      req_a = 1; addr_a = 4'd2; data_a = 32'h2222_0002;
      init = 1;
      run_scrub();
      exp_gnt_a(4'd2, 32'h2222_0002); cycle();
      req_a = 0;
      exp_idle(); cycle();

      // init beats a request sampled at the same edge.
      tag = "init_req_b";
      req_b = 1; addr_b = 4'd7; data_b = 32'h7777_0007;
      init = 1;
      run_scrub();
      exp_gnt_b(4'd7, 32'h7777_0007); cycle();
      req_b = 0;
      exp_idle(); cycle();

      // Reset during scrub entry 4 clears outputs at once and cancels done.
      tag = "reset_mid_scrub";
      init = 1;
      for (int i = 0; i < 5; i++) begin
         exp_scrub(4'(i));
         cycle();
         if (i == 0) init = 1'b0;
      end
      #2;
      apply_reset();
      reset_n = 1'b1;
      for (int i = 0; i < NREG + 2; i++) begin
         exp_idle(); cycle();
      end
      tag = "after_abort";
      req_a = 1; addr_a = 4'd1; data_a = 32'h0BAD_F00D;
      exp_gnt_a(4'd1, 32'h0BAD_F00D); cycle();
      req_a = 0;
      exp_idle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
